file_reg_write_control: RTL
===========================

# file_reg_write_control

File-register write-back and operand-fetch block for the PIC16C5x core. It holds the 25 general-purpose registers (0x07–0x1F) and the FSR, and resolves direct and INDF-indirect addressing. It latches the f-operand for the ALU during Q2 and performs every destination-f write in the Q4 execute state. It is the file-side counterpart of the W-register write control: it consumes W and the ALU result when the destination bit d = 1, or when the instruction always targets f. Writes to TMR0, PCL, STATUS, PORTA and PORTB are forwarded as a strobe to their owning blocks.

## Interface
- `DATA_WIDTH`: 8 (from define.v); file-register data width.
- `EX_STATE_BITS`: from define.v; width of executeState.
- `clk`  input  1  core clock.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `IR`  input  8  instruction low byte: f = IR[4:0], d = IR[5].
- `executeState`  input  EX_STATE_BITS  execute state (`EX_Q1`…`EX_Q4_*` codes from define.v).
- `aluResultIn`  input  DATA_WIDTH  ALU result.
- `wRIn`  input  DATA_WIDTH  current W register.
- `sfrRdData`  input  DATA_WIDTH  read data for the external SFR at `sfrAddr`.
- `gprOut`  output  DATA_WIDTH  latched f-operand to the ALU and W control.
- `fsrOut`  output  DATA_WIDTH  FSR value; bits 7:5 always read 1.
- `sfrAddr`  output  5  resolved file address (registered).
- `sfrWrEn`  output  1  one-cycle write strobe for external SFRs.
- `sfrWrData`  output  DATA_WIDTH  data accompanying `sfrWrEn`.

## Operation
- Address resolution:
  - resolved = (f == 0) ? FSR[4:0] : f.
  - Resolved 0 (INDF via FSR = 0) is a null register: reads give 0, writes are dropped.
- Address map:
  - 0x04: FSR, internal; 5 storage bits.
  - 0x07–0x1F: GPR array, internal.
  - 0x01, 0x02, 0x03, 0x05, 0x06: external SFRs.
- EX_Q2 edge actions:
  - addrReg ← resolved; `sfrAddr` ← resolved.
  - `gprOut` ← GPR[resolved], {3'b111, FSR}, `sfrRdData`, or 0, according to the resolved address.
  - addrReg is used for the Q4 write, so an FSR change in the same instruction does not redirect it.
- Q4 write data by state (target = addrReg):
  - `EX_Q4_CLRF`: 0.
  - `EX_Q4_MOVWF`: `wRIn`.
  - `EX_Q4_BXF`: `aluResultIn`.
  - `EX_Q4_FSZ`, `EX_Q4_ELSE`: `aluResultIn`, only if IR[5] = 1.
  - `EX_Q4_MOVF`: the latched `gprOut`, only if IR[5] = 1. The value is unchanged, but the strobe is still issued.
  - All other states: no write.
- Write routing:
  - GPR target: the array entry is updated.
  - FSR target: FSR ← data[4:0].
  - External SFR target: `sfrWrEn` = 1 and `sfrWrData` = data for the next cycle.
  - Null target: nothing changes and no strobe is issued.
- Reset (async, asserted at any time, including mid-instruction):
  - All GPRs = 0; FSR = 0, so `fsrOut` = 8'hE0.
  - `gprOut` = 0, `sfrAddr` = 0, `sfrWrEn` = 0, `sfrWrData` = 0.
  - addrReg = 0; any pending Q4 write is discarded.

## Timing
- Each executeState code is held for exactly one clk; one instruction spans Q1–Q4 in four clocks.
- `gprOut` is valid from the clock after the Q2 edge and is held until the next Q2 edge. The ALU uses it in Q3/Q4.
- Internal writes (GPR, FSR) are visible on the clock edge that ends the Q4 state.
- `sfrWrEn` is registered: it is high for exactly one clk, starting at the edge that ends Q4, with `sfrAddr`/`sfrWrData` stable for that clk. It is never high in two consecutive cycles.
- Back-to-back instructions:
  - Q2 of instruction n+1 sees the Q4 write of instruction n (read-after-write through the array, no bypass needed).
  - INDF addressing in instruction n+1 uses the FSR value written by instruction n.
- Self-referential write: when INDF resolves to 0x04, the write targets FSR itself. The new value is used from the next instruction's Q2 onward.
- `fsrOut` is continuously driven from FSR and is not delayed by the Q2 latch.

## Test plan
- Reset sequence: assert rst_n = 0 mid-Q3 -> `fsrOut` = 8'hE0, `gprOut` = 0, `sfrWrEn` = 0 immediately; a read of 0x1F after release returns 0.
- MOVWF with W = 8'hA5, f = 0x10, then MOVF 0x10 with d = 0 -> `gprOut` = 8'hA5 after the next Q2; no `sfrWrEn`.
- Indirect write: MOVWF 0x04 with W = 8'h0C, then MOVWF INDF with W = 8'h3C -> GPR 0x0C = 8'h3C; `fsrOut` = 8'hEC.
- INDF with FSR = 0, CLRF 0x00 -> no register changes and no strobe; `gprOut` reads 0.
- External SFR write: ELSE state, d = 1, f = 0x06, `aluResultIn` = 8'h5A -> `sfrWrEn` high for one clk with `sfrAddr` = 0x06 and `sfrWrData` = 8'h5A. The same with d = 0 -> no strobe.
- FSZ with d = 1, f = 0x07, `aluResultIn` = 8'h00, followed immediately by a Q2 read of 0x07 -> `gprOut` = 0; with d = 0 the value is unchanged.

Source files
------------

// File: rtl/file_reg_write_control_if.sv
// Shared execute-state codes and the bus that connects the file-register
// block to the rest of the PIC16C5x core.
package file_reg_pkg;
  localparam int DATA_WIDTH    = 8;
  localparam int EX_STATE_BITS = 4;

  localparam logic [EX_STATE_BITS-1:0] EX_Q1       = 4'd0;
  localparam logic [EX_STATE_BITS-1:0] EX_Q2       = 4'd1;
  localparam logic [EX_STATE_BITS-1:0] EX_Q3       = 4'd2;
  localparam logic [EX_STATE_BITS-1:0] EX_Q4_CLRF  = 4'd3;
  localparam logic [EX_STATE_BITS-1:0] EX_Q4_MOVWF = 4'd4;
  localparam logic [EX_STATE_BITS-1:0] EX_Q4_BXF   = 4'd5;
  localparam logic [EX_STATE_BITS-1:0] EX_Q4_FSZ   = 4'd6;
  localparam logic [EX_STATE_BITS-1:0] EX_Q4_ELSE  = 4'd7;
  localparam logic [EX_STATE_BITS-1:0] EX_Q4_MOVF  = 4'd8;
  localparam logic [EX_STATE_BITS-1:0] EX_Q4_NOP   = 4'd9;
endpackage

// Handshake: there is no valid/ready pair on this bus. Inputs are sampled
// according to executeState; sfrWrEn is a registered single-cycle strobe
// that the owning SFR block must accept unconditionally, with sfrAddr and
// sfrWrData stable while it is high.
interface file_reg_write_control_if #(
  parameter int DATA_WIDTH    = file_reg_pkg::DATA_WIDTH,
  parameter int EX_STATE_BITS = file_reg_pkg::EX_STATE_BITS
);
  logic [7:0]               IR;
  logic [EX_STATE_BITS-1:0] executeState;
  logic [DATA_WIDTH-1:0]    aluResultIn;
  logic [DATA_WIDTH-1:0]    wRIn;
  logic [DATA_WIDTH-1:0]    sfrRdData;
  logic [DATA_WIDTH-1:0]    gprOut;
  logic [DATA_WIDTH-1:0]    fsrOut;
  logic [4:0]               sfrAddr;
  logic                     sfrWrEn;
  logic [DATA_WIDTH-1:0]    sfrWrData;

  modport master (
    output IR, executeState, aluResultIn, wRIn, sfrRdData,
    input  gprOut, fsrOut, sfrAddr, sfrWrEn, sfrWrData
  );

  modport slave (
    input  IR, executeState, aluResultIn, wRIn, sfrRdData,
    output gprOut, fsrOut, sfrAddr, sfrWrEn, sfrWrData
  );
endinterface

// File: rtl/file_reg_write_control.sv
// File-register operand fetch (Q2) and write-back (Q4) for the PIC16C5x
// core: GPR array 0x07-0x1F, FSR, INDF indirection, external SFR strobe.
module file_reg_write_control
  import file_reg_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  file_reg_write_control_if.slave   bus
);
  localparam int DW = DATA_WIDTH;

  logic [DW-1:0] gpr_q [7:31];
  logic [DW-1:0] gpr_d [7:31];
  logic [4:0]    fsr_q, fsr_d;
  logic [4:0]    addr_q, addr_d;
  logic [4:0]    sfr_addr_q, sfr_addr_d;
  logic [DW-1:0] gpr_out_q, gpr_out_d;
  logic          sfr_wr_en_q, sfr_wr_en_d;
  logic [DW-1:0] sfr_wr_data_q, sfr_wr_data_d;

  logic [4:0]    resolved;
  logic [DW-1:0] rd_data;
  logic          wr_req;
  logic [DW-1:0] wr_data;
  logic          unused_ir;

  assign unused_ir = ^bus.IR[7:6];

  // Registers at 0x01-0x03, 0x05, 0x06 live in other blocks.
  function automatic logic is_ext_sfr(input logic [4:0] a);
    return (a == 5'd1) || (a == 5'd2) || (a == 5'd3) ||
           (a == 5'd5) || (a == 5'd6);
  endfunction

  // Resolve INDF through FSR and select the read source for that address.
  always_comb begin
    resolved = (bus.IR[4:0] == 5'd0) ? fsr_q : bus.IR[4:0];
    rd_data  = '0;
    if (resolved >= 5'd7)        rd_data = gpr_q[resolved];
    else if (resolved == 5'd4)   rd_data = {3'b111, fsr_q};
    else if (is_ext_sfr(resolved)) rd_data = bus.sfrRdData;
  end

  // Decide whether this Q4 state writes f, and with what data.
  always_comb begin
    wr_req  = 1'b0;
    wr_data = '0;
    case (bus.executeState)
      EX_Q4_CLRF:  begin wr_req = 1'b1;      wr_data = '0;              end
      EX_Q4_MOVWF: begin wr_req = 1'b1;      wr_data = bus.wRIn;        end
      EX_Q4_BXF:   begin wr_req = 1'b1;      wr_data = bus.aluResultIn; end
      EX_Q4_FSZ,
      EX_Q4_ELSE:  begin wr_req = bus.IR[5]; wr_data = bus.aluResultIn; end
      EX_Q4_MOVF:  begin wr_req = bus.IR[5]; wr_data = gpr_out_q;       end
      default:     begin wr_req = 1'b0;      wr_data = '0;              end
    endcase
  end

  // Next-state: latch operand/address in Q2, route the Q4 write via addr_q
  // so an FSR update inside the same instruction cannot redirect it.
  always_comb begin
    gpr_d         = gpr_q;
    fsr_d         = fsr_q;
    addr_d        = addr_q;
    sfr_addr_d    = sfr_addr_q;
    gpr_out_d     = gpr_out_q;
    sfr_wr_en_d   = 1'b0;
    sfr_wr_data_d = sfr_wr_data_q;
    if (bus.executeState == EX_Q2) begin
      addr_d     = resolved;
      sfr_addr_d = resolved;
      gpr_out_d  = rd_data;
    end
    if (wr_req) begin
      if (addr_q >= 5'd7) begin
        gpr_d[addr_q] = wr_data;
      end else if (addr_q == 5'd4) begin
        fsr_d = wr_data[4:0];
      end else if (is_ext_sfr(addr_q)) begin
        sfr_wr_en_d   = 1'b1;
        sfr_wr_data_d = wr_data;
      end
    end
  end

  // State registers; reset clears everything and drops any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 7; i <= 31; i++) gpr_q[i] <= '0;
      fsr_q         <= '0;
      addr_q        <= '0;
      sfr_addr_q    <= '0;
      gpr_out_q     <= '0;
      sfr_wr_en_q   <= 1'b0;
      sfr_wr_data_q <= '0;
    end else begin
      gpr_q         <= gpr_d;
      fsr_q         <= fsr_d;
      addr_q        <= addr_d;
      sfr_addr_q    <= sfr_addr_d;
      gpr_out_q     <= gpr_out_d;
      sfr_wr_en_q   <= sfr_wr_en_d;
      sfr_wr_data_q <= sfr_wr_data_d;
    end
  end

  assign bus.gprOut    = gpr_out_q;
  assign bus.fsrOut    = {3'b111, fsr_q};
  assign bus.sfrAddr   = sfr_addr_q;
  assign bus.sfrWrEn   = sfr_wr_en_q;
  assign bus.sfrWrData = sfr_wr_data_q;
endmodule
